rr_arbiter_8: RTL and testbench

Round-robin arbiter that shares one downstream resource among 8 requesters. Requester i gets exclusive ownership until it signals completion, drops its request, or exceeds a hold limit. It drives a registered one-hot grant and the matching 3-bit encoded index to the shared datapath's select logic. Priority rotates after every release, so no requester starves.

---
 rtl/rr_arbiter_8.sv | 138 +++++++++++++
 tb/tb_rr_arbiter_8.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 -- round-robin arbiter sharing one resource among 8 requesters.
//
// A grant is held by one owner until it pulses its done bit, drops its
// request, or has been held for MAX_HOLD cycles (MAX_HOLD = 0 disables the
// limit). After each release the search pointer moves to owner+1, and one
// idle cycle always separates consecutive grants.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   req_i[7:0]  request per requester
//   done_i[7:0] release strobe; only the current owner's bit is honoured
//   gnt_o[7:0]  registered one-hot grant, zero when idle
//   gnt_idx_o   binary index of the asserted grant bit, zero when idle
//   gnt_vld_o   high while any grant is asserted
//   timeout_o   one-cycle pulse when the hold limit alone forced a release
module rr_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] req_i,
   input  logic [7:0] done_i,
   output logic [7:0] gnt_o,
   output logic [2:0] gnt_idx_o,
   output logic       gnt_vld_o,
   output logic       timeout_o
);

   localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HLIM = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      ptr_q, ptr_d;
   logic [2:0]      own_q, own_d;
   logic [HW-1:0]   hcnt_q, hcnt_d;
   logic [7:0]      gnt_q, gnt_d;
   logic [2:0]      idx_q, idx_d;
   logic            vld_q, vld_d;
   logic            to_q, to_d;

   // First requester at or after ptr_q, wrapping modulo 8.
   logic [2:0] pick;
   logic [2:0] cand;
   logic       found;

   always_comb begin
      pick  = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
         cand = ptr_q + 3'(k);
         if (!found && req_i[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   logic rel_norm;
   logic hit_lim;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      own_d    = own_q;
      hcnt_d   = hcnt_q;
      gnt_d    = '0;
      idx_d    = '0;
      vld_d    = 1'b0;
      to_d     = 1'b0;
      rel_norm = done_i[own_q] || !req_i[own_q];
      hit_lim  = (MAX_HOLD != 0) && (hcnt_q == HLIM);

      case (state_q)
         IDLE: begin
            if (found) begin
               own_d   = pick;
               hcnt_d  = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (hcnt_q != '1) begin
               hcnt_d = hcnt_q + 1'b1;
            end
            if (rel_norm || hit_lim) begin
               state_d = IDLE;
               ptr_d   = own_q + 3'd1;
               // A normal release coinciding with the limit is not a timeout.
               to_d    = hit_lim && !rel_norm;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next-state view so they line up
      // with the state they describe.
      if (state_d == GRANT) begin
         gnt_d = 8'b1 << own_d;
         idx_d = own_d;
         vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         own_q   <= '0;
         hcnt_q  <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
         hcnt_q  <= hcnt_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         to_q    <= to_d;
      end
   end

   assign gnt_o     = gnt_q;
   assign gnt_idx_o = idx_q;
   assign gnt_vld_o = vld_q;
   assign timeout_o = to_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8 -- scoreboard bench for rr_arbiter_8 with MAX_HOLD = 4.
//
// Each stimulus cycle drives inputs on the falling edge, advances a
// behavioural model (owner or none, held-cycle count, search start) and
// pushes the outputs expected after the next rising edge. A separate
// monitor pops one entry after every rising edge and compares.
module tb_rr_arbiter_8;

   localparam int MH = 4;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .done_i    (done),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld),
      .timeout_o (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       vld;
      logic       to;
   } out_t;

   out_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: owner index or -1, cycles the current grant
   // has been visible, and where the next search starts.
   int m_owner = -1;
   int m_held  = 0;
   int m_next  = 0;
   int m_to    = 0;

   task automatic model_step(input logic [7:0] r, input logic [7:0] d, input logic rs);
      out_t e;
      int   norm;
      int   lim;
      if (rs) begin
         m_owner = -1; m_held = 0; m_next = 0; m_to = 0;
      end else if (m_owner < 0) begin
         m_to = 0;
         for (int k = 0; k < 8; k++) begin
            if (m_owner < 0 && r[(m_next + k) % 8]) begin
               m_owner = (m_next + k) % 8;
               m_held  = 1;
            end
         end
      end else begin
         norm = (d[m_owner] || !r[m_owner]) ? 1 : 0;
         lim  = (MH != 0 && m_held == MH) ? 1 : 0;
         if (norm != 0 || lim != 0) begin
            m_to    = (lim != 0 && norm == 0) ? 1 : 0;
            m_next  = (m_owner + 1) % 8;
            m_owner = -1;
            m_held  = 0;
         end else begin
            m_held = m_held + 1;
            m_to   = 0;
         end
      end
      e.gnt = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
      e.idx = (m_owner < 0) ? 3'd0 : 3'(m_owner);
      e.vld = (m_owner >= 0);
      e.to  = (m_to != 0);
      exp_q.push_back(e);
   endtask

   task automatic cycle(input logic [7:0] r, input logic [7:0] d, input logic rs);
      @(negedge clk);
      req  = r;
      done = d;
      rst  = rs;
      model_step(r, d, rs);
   endtask

   // Owner pulses done on the given grant cycle (0 = never).
   function automatic logic [7:0] done_on(input int cyc);
      if (m_owner >= 0 && cyc != 0 && m_held == cyc) return 8'(1 << m_owner);
      return 8'h00;
   endfunction

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s wait expired: got owner=%0d, required target not reached", name, m_owner);
   endtask

   // Monitor: compare after every rising edge that has an expectation.
   initial begin
      out_t e;
      out_t a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{gnt: gnt, idx: gnt_idx, vld: gnt_vld, to: timeout};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs t=%0t got gnt=%h idx=%0d vld=%b to=%b required gnt=%h idx=%0d vld=%b to=%b",
                        $time, a.gnt, a.idx, a.vld, a.to, e.gnt, e.idx, e.vld, e.to);
            end
         end
      end
   end

   initial begin
      int n;
      logic [7:0] r;
      logic [7:0] d;
      req = '0; done = '0; rst = 1'b1;

      // Reset with all requests, then first grant goes to 0.
      for (int i = 0; i < 3; i++) cycle(8'hFF, 8'h00, 1'b1);
      // Rotation: every owner releases on its 2nd grant cycle.
      for (int i = 0; i < 30; i++) cycle(8'hFF, done_on(2), 1'b0);

      // Skip and wrap: after owner 5 releases, only 0 and 3 request.
      n = 0;
      while (!(m_owner == 5 && m_held == 2) && n < 40) begin
         cycle(8'hFF, done_on(2), 1'b0);
         n++;
      end
      if (n >= 40) bound_fail("reach_owner5");
      cycle(8'hFF, 8'h20, 1'b0);
      for (int i = 0; i < 10; i++) cycle(8'b0000_1001, done_on(2), 1'b0);

      // Timeout: requester 2 holds forever, then releases on grant cycle 4.
      for (int i = 0; i < 14; i++) cycle(8'h04, 8'h00, 1'b0);
      for (int i = 0; i < 14; i++) cycle(8'h04, done_on(4), 1'b0);

      // Ignored inputs while 3 owns, then 3 drops its request.
      cycle(8'h00, 8'h00, 1'b0);
      cycle(8'h00, 8'h00, 1'b0);
      n = 0;
      while (m_owner != 3 && n < 20) begin
         cycle(8'h08, 8'h00, 1'b0);
         n++;
      end
      if (n >= 20) bound_fail("reach_owner3");
      cycle(8'h48, 8'h40, 1'b0);
      cycle(8'h08, 8'h40, 1'b0);
      cycle(8'h40, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) cycle(8'h40, 8'h00, 1'b0);

      // Reset mid-grant while 7 owns; pointer returns to 0.
      cycle(8'h00, 8'h00, 1'b0);
      cycle(8'h00, 8'h00, 1'b0);
      n = 0;
      while (m_owner != 7 && n < 20) begin
         cycle(8'h80, 8'h00, 1'b0);
         n++;
      end
      if (n >= 20) bound_fail("reach_owner7");
      cycle(8'h80, 8'h00, 1'b0);
      cycle(8'h81, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) cycle(8'h81, 8'h00, 1'b0);

      // Randomized traffic; owner mostly keeps its request.
      for (int i = 0; i < 3000; i++) begin
         r = 8'($urandom);
         if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
         d = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
         cycle(r, d, ($urandom_range(0, 149) == 0));
      end

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
